// File: rtl/uart_echo_sched_if.sv
// Echo-path bus between the RAM-backed scheduler and its environment:
// uart_rx bytes in, RAM write/read port, uart_tx2 handshake and queue status.
interface uart_echo_sched_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              flush;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_din;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        ram_dout;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              overflow;

    modport slave (
        input  rx_dv, rx_byte, flush, ram_dout, tx_done,
        output ram_we, ram_waddr, ram_din, ram_raddr, tx_dv, tx_byte,
               level, empty, full, overflow
    );

    modport master (
        output rx_dv, rx_byte, flush, ram_dout, tx_done,
        input  ram_we, ram_waddr, ram_din, ram_raddr, tx_dv, tx_byte,
               level, empty, full, overflow
    );
endinterface

// File: rtl/uart_echo_sched.sv
// RAM-backed FIFO scheduler between uart_rx and uart_tx2 with full/empty/overflow
// tracking and flush. Define UART_ECHO_SCHED_CRLF_EN to expand CR into CR+LF.
module uart_echo_sched #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic          ICE_CLK,
    input  logic          RST_N,
    uart_echo_sched_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_LF    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    logic full_c, empty_c, wr_acc_c, deq_c;

    // Status comes from the registered level only, never from pointer compare.
    always_comb begin
        full_c   = (level_q == LVL_W'(DEPTH));
        empty_c  = (level_q == '0);
        wr_acc_c = bus.rx_dv & ~full_c & ~bus.flush;
        deq_c    = (state_q == S_IDLE) & ~empty_c & ~bus.flush;
    end

    // Queue bookkeeping; flush clears everything and wins over a same-cycle write.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc_c) wptr_d = wptr_q + ADDR_W'(1);
            if (deq_c)    rptr_d = rptr_q + ADDR_W'(1);
            level_d = level_q + LVL_W'(wr_acc_c) - LVL_W'(deq_c);
            if (bus.rx_dv & full_c) overflow_d = 1'b1;
        end
    end

    // Read sequencer: RAM data is valid during FETCH and is captured on the way
    // into LOAD, so the registered tx_dv pulse coincides with the LOAD cycle.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if (deq_c) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d   = S_LOAD;
                tx_byte_d = bus.ram_dout;
                tx_dv_d   = 1'b1;
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
`ifdef UART_ECHO_SCHED_CRLF_EN
                    if (tx_byte_q == 8'h0D) begin
                        state_d   = S_LF;
                        tx_byte_d = 8'h0A;
                        tx_dv_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_LF: begin
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign bus.ram_we    = wr_acc_c;
    assign bus.ram_waddr = wptr_q;
    assign bus.ram_din   = bus.rx_byte;
    assign bus.ram_raddr = rptr_q;
    assign bus.tx_dv     = tx_dv_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.level     = level_q;
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_echo_sched.sv
// Scoreboard bench for uart_echo_sched: sync-read RAM model, uart_tx2 responder,
// expected tx bytes queued at stimulus time and checked by an independent monitor.
module tb_uart_echo_sched;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_echo_sched_if #(.ADDR_W(ADDR_W)) bus ();

    uart_echo_sched #(.ADDR_W(ADDR_W)) dut (
        .ICE_CLK(clk),
        .RST_N  (rst_n),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [ADDR_W-1:0] exp_wptr = '0;
    int  tx_gap  = 2;
    bit  tx_hold = 1'b0;
    int  tx_cnt  = 0;
    logic prev_dv = 1'b0;

    // Synchronous-read RAM: dout reflects the address presented on the previous edge.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // uart_tx2 stand-in: tx_done pulses tx_gap cycles after tx_dv unless held off.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (bus.tx_dv === 1'b1) begin
                tx_cnt = tx_gap;
            end else if (tx_cnt > 0 && !tx_hold) begin
                tx_cnt--;
                if (tx_cnt == 0) bus.tx_done = 1'b1;
            end
        end
    end

    // Monitor: every tx_dv pulse must be one cycle wide and match the next expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n === 1'b1 && bus.tx_dv === 1'b1) begin
            chk("tx_dv_width", 32'(prev_dv), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: tx_dv with byte 0x%0h, expected no transmit (t=%0t)",
                         bus.tx_byte, $time);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", 32'(bus.tx_byte), 32'(e));
            end
        end
        prev_dv = bus.tx_dv;
    end

    task automatic send(input logic [7:0] b, input bit acc);
        @(negedge clk);
        bus.rx_byte = b;
        bus.rx_dv   = 1'b1;
        #1;
        chk("ram_we", 32'(bus.ram_we), 32'(acc));
        if (acc) begin
            chk("ram_waddr", 32'(bus.ram_waddr), 32'(exp_wptr));
            chk("ram_din", 32'(bus.ram_din), 32'(b));
            exp_wptr = exp_wptr + ADDR_W'(1);
            exp_q.push_back(b);
`ifdef UART_ECHO_SCHED_CRLF_EN
            if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
        end
        @(negedge clk);
        bus.rx_dv = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || bus.empty !== 1'b1) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (8) @(negedge clk);
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_level"}, 32'(bus.level), 32'd0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_tx_dv"}, 32'(bus.tx_dv), 32'd0);
        chk({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_raddr"}, 32'(bus.ram_raddr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
        bus.flush   = 1'b0;
        #1;
        chk_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single byte: written at addr 0, tx_dv exactly three cycles after rx_dv.
        send(8'h41, 1'b1);
        chk("t1_level_c1", 32'(bus.level), 32'd1);
        chk("t1_tx_dv_c1", 32'(bus.tx_dv), 32'd0);
        @(negedge clk);
        chk("t1_tx_dv_c2", 32'(bus.tx_dv), 32'd0);
        chk("t1_level_c2", 32'(bus.level), 32'd0);
        @(negedge clk);
        chk("t1_tx_dv_c3", 32'(bus.tx_dv), 32'd1);
        chk("t1_tx_byte_c3", 32'(bus.tx_byte), 32'h41);
        drain(100);

        // Burst faster than the transmitter.
        for (int b = 8'h30; b <= 8'h39; b++) send(8'(b), 1'b1);
        chk("t2_backlog", 32'(bus.level != '0), 32'd1);
        drain(400);

        // Fill with tx_done held off: one byte in flight plus 512 queued.
        tx_hold = 1'b1;
        for (int i = 0; i < 513; i++) send(8'(i), 1'b1);
        #1;
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_level", 32'(bus.level), 32'd512);
        chk("t3_overflow_pre", 32'(bus.overflow), 32'd0);
        send(8'hEE, 1'b0);
        chk("t3_overflow", 32'(bus.overflow), 32'd1);
        chk("t3_level_kept", 32'(bus.level), 32'd512);
        tx_hold = 1'b0;
        drain(8000);
        chk("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

        // Long stream while draining: both pointers wrap past 511.
        for (int i = 0; i < 600; i++) send(8'(i * 7 + 3), 1'b1);
        drain(8000);

        // Flush during WAIT with five queued.
        tx_hold = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b1);
        repeat (6) @(negedge clk);
        chk("t5_level_pre", 32'(bus.level), 32'd5);
        chk("t5_sb_pending", 32'(exp_q.size()), 32'd5);
        bus.flush = 1'b1;
        exp_q.delete();
        exp_wptr = '0;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("t5_level", 32'(bus.level), 32'd0);
        chk("t5_empty", 32'(bus.empty), 32'd1);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        chk("t5_raddr", 32'(bus.ram_raddr), 32'd0);
        tx_hold = 1'b0;
        repeat (20) @(negedge clk);
        bus.flush   = 1'b1;
        bus.rx_dv   = 1'b1;
        bus.rx_byte = 8'h55;
        #1;
        chk("t5_flush_wins", 32'(bus.ram_we), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.rx_dv = 1'b0;
        chk("t5_level_after", 32'(bus.level), 32'd0);
        repeat (10) @(negedge clk);
        send(8'h5A, 1'b1);
        drain(100);

        // CR handling (LF inserted only when the expansion is built in).
        send(8'h0D, 1'b1);
        send(8'h42, 1'b1);
        drain(200);

        // Asynchronous reset while waiting on tx_done.
        tx_hold = 1'b1;
        send(8'h77, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_in_flight", 32'(bus.tx_byte), 32'h77);
        send(8'h78, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        exp_q.delete();
        exp_wptr = '0;
        tx_hold  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_stale_tx", 32'(bus.tx_dv), 32'd0);
        send(8'h12, 1'b1);
        drain(100);

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
